// File: rtl/spike_dispatcher.sv
// spike_dispatcher: walks an N x N adjacency weight table for each accepted
// spike vector and emits one (src, dst, weight) event per live pair, in
// ascending pair order p = src*N + dst, over a valid/ready handshake.
//
// Ports
//   clk, reset              clock and synchronous active-high reset
//   spike_in/valid/ready    spike vector input (accepted only in IDLE)
//   wr_en/src/dst/weight    adjacency weight write port (any state)
//   ev_valid/ready          event handshake toward the accumulator
//   ev_src/dst/weight       event payload, held stable while ev_valid=1
//   done                    one-cycle pulse after the last pair of a vector
module spike_dispatcher #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         spike_in,
  input  logic                 spike_valid,
  output logic                 spike_ready,
  input  logic                 wr_en,
  input  logic [$clog2(N)-1:0] wr_src,
  input  logic [$clog2(N)-1:0] wr_dst,
  input  logic [W-1:0]         wr_weight,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [$clog2(N)-1:0] ev_src,
  output logic [$clog2(N)-1:0] ev_dst,
  output logic [W-1:0]         ev_weight,
  output logic                 done
);

  localparam int unsigned LW = $clog2(N);
  localparam int unsigned PW = 2 * LW;
  localparam int unsigned NP = N * N;
  localparam logic [PW-1:0] LAST_PAIR = PW'(NP - 1);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   spikes_q, spikes_d;
  logic [PW-1:0]  pair_q, pair_d;
  logic [LW-1:0]  ev_src_q, ev_src_d;
  logic [LW-1:0]  ev_dst_q, ev_dst_d;
  logic [W-1:0]   ev_weight_q, ev_weight_d;
  logic           spike_ready_q, ev_valid_q, done_q;
  logic [W-1:0]   weight_q [NP];

  logic [LW-1:0]  scan_src, scan_dst;
  logic [W-1:0]   scan_w;
  logic           live;

  // Pair index splits directly into {src, dst} because N is a power of two.
  assign scan_src = pair_q[PW-1:LW];
  assign scan_dst = pair_q[LW-1:0];
  assign scan_w   = weight_q[pair_q];
  assign live     = spikes_q[scan_src] && (scan_src != scan_dst) && (scan_w != '0);

  // Weight table; reset wipes every entry and wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NP); i++) begin
        weight_q[i] <= '0;
      end
    end else if (wr_en) begin
      weight_q[{wr_src, wr_dst}] <= wr_weight;
    end
  end

  // State and payload registers; status outputs are registered from state_d.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      spikes_q      <= '0;
      pair_q        <= '0;
      ev_src_q      <= '0;
      ev_dst_q      <= '0;
      ev_weight_q   <= '0;
      spike_ready_q <= 1'b1;
      ev_valid_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      spikes_q      <= spikes_d;
      pair_q        <= pair_d;
      ev_src_q      <= ev_src_d;
      ev_dst_q      <= ev_dst_d;
      ev_weight_q   <= ev_weight_d;
      spike_ready_q <= (state_d == IDLE);
      ev_valid_q    <= (state_d == EMIT);
      done_q        <= (state_d == DONE);
    end
  end

  // Next-state logic; the pair counter only advances once a pair is finished.
  always_comb begin
    state_d     = state_q;
    spikes_d    = spikes_q;
    pair_d      = pair_q;
    ev_src_d    = ev_src_q;
    ev_dst_d    = ev_dst_q;
    ev_weight_d = ev_weight_q;
    case (state_q)
      IDLE: begin
        if (spike_valid) begin
          spikes_d = spike_in;
          pair_d   = '0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (live) begin
          ev_src_d    = scan_src;
          ev_dst_d    = scan_dst;
          ev_weight_d = scan_w;
          state_d     = EMIT;
        end else if (pair_q == LAST_PAIR) begin
          state_d = DONE;
        end else begin
          pair_d = pair_q + PW'(1);
        end
      end
      EMIT: begin
        if (ev_ready) begin
          if (pair_q == LAST_PAIR) begin
            state_d = DONE;
          end else begin
            pair_d  = pair_q + PW'(1);
            state_d = SCAN;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign spike_ready = spike_ready_q;
  assign ev_valid    = ev_valid_q;
  assign ev_src      = ev_src_q;
  assign ev_dst      = ev_dst_q;
  assign ev_weight   = ev_weight_q;
  assign done        = done_q;

endmodule

// File: tb/tb_spike_dispatcher.sv
// Directed bench for spike_dispatcher (N=4, W=8): event order, stall hold,
// empty-vector latency, skip rules, reset mid-emit and in-pass weight writes.
module tb_spike_dispatcher;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] spike_in;
  logic       spike_valid;
  logic       spike_ready;
  logic       wr_en;
  logic [1:0] wr_src, wr_dst;
  logic [7:0] wr_weight;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_src, ev_dst;
  logic [7:0] ev_weight;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  int         n_ev, n_done;
  logic [1:0] cs [8];
  logic [1:0] cd [8];
  logic [7:0] cw [8];

  spike_dispatcher #(.N(4), .W(8)) dut (
    .clk(clk), .reset(reset),
    .spike_in(spike_in), .spike_valid(spike_valid), .spike_ready(spike_ready),
    .wr_en(wr_en), .wr_src(wr_src), .wr_dst(wr_dst), .wr_weight(wr_weight),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_src(ev_src), .ev_dst(ev_dst), .ev_weight(ev_weight),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic write_w(input logic [1:0] s, input logic [1:0] d, input logic [7:0] w);
    wr_en = 1'b1; wr_src = s; wr_dst = d; wr_weight = w;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic accept(input logic [3:0] v);
    spike_valid = 1'b1; spike_in = v;
    tick();
    spike_valid = 1'b0;
  endtask

  // Record handshaken events until a done pulse (bounded), then step past it.
  task automatic collect();
    bit fin;
    fin = 0; n_ev = 0; n_done = 0;
    for (int c = 0; c < 200 && !fin; c++) begin
      if (ev_valid && ev_ready) begin
        if (n_ev < 8) begin cs[n_ev] = ev_src; cd[n_ev] = ev_dst; cw[n_ev] = ev_weight; end
        n_ev++;
      end
      if (done) begin n_done++; fin = 1; end
      tick();
    end
  endtask

  task automatic wait_valid();
    for (int c = 0; c < 100 && !ev_valid; c++) tick();
  endtask

  initial begin
    int cnt;
    bit saw_ev;
    reset = 1'b1; spike_in = '0; spike_valid = 1'b0; wr_en = 1'b0;
    wr_src = '0; wr_dst = '0; wr_weight = '0; ev_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_spike_ready", 32'(spike_ready), 1);
    check("rst_ev_valid",    32'(ev_valid), 0);
    check("rst_ev_src",      32'(ev_src), 0);
    check("rst_ev_dst",      32'(ev_dst), 0);
    check("rst_ev_weight",   32'(ev_weight), 0);
    check("rst_done",        32'(done), 0);

    // Three events in ascending pair order, one done pulse.
    write_w(2'd0, 2'd1, 8'd5);
    write_w(2'd0, 2'd3, 8'd9);
    write_w(2'd2, 2'd0, 8'd7);
    ev_ready = 1'b1;
    accept(4'b0101);
    collect();
    check("basic_n_ev", 32'(n_ev), 3);
    check("basic_ev0", {cs[0], cd[0], cw[0]}, {2'd0, 2'd1, 8'd5});
    check("basic_ev1", {cs[1], cd[1], cw[1]}, {2'd0, 2'd3, 8'd9});
    check("basic_ev2", {cs[2], cd[2], cw[2]}, {2'd2, 2'd0, 8'd7});
    check("basic_done", 32'(n_done), 1);
    check("basic_done_pulse", 32'(done), 0);
    check("basic_idle", 32'(spike_ready), 1);

    // Stall on the first event; a spike vector offered mid-pass is ignored.
    ev_ready = 1'b0;
    accept(4'b0101);
    wait_valid();
    spike_valid = 1'b1; spike_in = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) ev_ready = 1'b1;
      check("stall_valid", 32'(ev_valid), 1);
      check("stall_payload", {ev_src, ev_dst, ev_weight}, {2'd0, 2'd1, 8'd5});
      check("stall_not_ready", 32'(spike_ready), 0);
      tick();
    end
    spike_valid = 1'b0;
    collect();
    check("stall_rest_n_ev", 32'(n_ev), 2);
    check("stall_ev1", {cs[0], cd[0], cw[0]}, {2'd0, 2'd3, 8'd9});
    check("stall_ev2", {cs[1], cd[1], cw[1]}, {2'd2, 2'd0, 8'd7});
    check("stall_done", 32'(n_done), 1);

    // Empty vector: N*N SCAN cycles plus the DONE cycle.
    accept(4'b0000);
    cnt = 1; saw_ev = 0;
    while (!done && cnt < 100) begin
      if (ev_valid) saw_ev = 1;
      tick();
      cnt++;
    end
    check("empty_latency", 32'(cnt), 17);
    check("empty_no_ev", 32'(saw_ev), 0);
    tick();
    check("empty_done_1cyc", 32'(done), 0);
    check("empty_idle", 32'(spike_ready), 1);

    // Self-loop and zero weight are skipped.
    write_w(2'd1, 2'd1, 8'd3);
    write_w(2'd1, 2'd2, 8'd0);
    accept(4'b0010);
    collect();
    check("skip_n_ev", 32'(n_ev), 0);
    check("skip_done", 32'(n_done), 1);

    // Reset while an event is pending; same-cycle write/spike lose to reset.
    ev_ready = 1'b0;
    accept(4'b0101);
    wait_valid();
    check("pre_rst_valid", 32'(ev_valid), 1);
    reset = 1'b1; spike_valid = 1'b1; spike_in = 4'b0001;
    wr_en = 1'b1; wr_src = 2'd0; wr_dst = 2'd1; wr_weight = 8'd8;
    tick();
    reset = 1'b0; spike_valid = 1'b0; wr_en = 1'b0;
    check("mid_rst_ev_valid", 32'(ev_valid), 0);
    check("mid_rst_ready", 32'(spike_ready), 1);
    check("mid_rst_payload", {ev_src, ev_dst, ev_weight}, 12'h000);
    ev_ready = 1'b1;
    accept(4'b0001);
    collect();
    check("cleared_n_ev", 32'(n_ev), 0);
    check("cleared_done", 32'(n_done), 1);

    // A write to a not-yet-examined pair lands in the current pass.
    accept(4'b1000);
    write_w(2'd3, 2'd2, 8'd4);
    collect();
    check("late_wr_n_ev", 32'(n_ev), 1);
    check("late_wr_ev", {cs[0], cd[0], cw[0]}, {2'd3, 2'd2, 8'd4});
    check("late_wr_done", 32'(n_done), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spike_dispatcher.md
SPIKE_DISPATCHER -- requirements
Module: spike_dispatcher

Interface
REQ-001 SHALL have parameter N, default 4, meaning node count (N a power of two, N >= 2).
REQ-002 SHALL have parameter W, default 8, meaning weight and event data width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port spike_in  input  N  spike vector; bit i set = node i fired.
REQ-006 SHALL have port spike_valid  input  1  spike_in is valid this cycle.
REQ-007 SHALL have port spike_ready  output  1  block accepts a spike vector this cycle.
REQ-008 SHALL have port wr_en  input  1  write one adjacency weight.
REQ-009 SHALL have port wr_src  input  log2(N)  source node index of the write.
REQ-010 SHALL have port wr_dst  input  log2(N)  destination node index of the write.
REQ-011 SHALL have port wr_weight  input  W  unsigned weight written to entry (wr_src, wr_dst).
REQ-012 SHALL have port ev_valid  output  1  an event is presented.
REQ-013 SHALL have port ev_ready  input  1  downstream accumulator accepts the event.
REQ-014 SHALL have port ev_src  output  log2(N)  source index of the event.
REQ-015 SHALL have port ev_dst  output  log2(N)  destination index of the event.
REQ-016 SHALL have port ev_weight  output  W  weight to be added at ev_dst.
REQ-017 SHALL have port done  output  1  one-cycle pulse: all events for the accepted vector have been delivered.

Function
REQ-018 SHALL hold an N x N weight table; an entry is written on the posedge where wr_en=1, in any state.
REQ-019 SHALL implement states IDLE, SCAN, EMIT, DONE; spike_ready=1 only in IDLE.
REQ-020 SHALL, in IDLE with spike_valid=1, latch spike_in, clear the pair counter to 0 and enter SCAN next cycle (including when spike_in is all zeros).
REQ-021 SHALL, in SCAN, examine one pair per cycle, pair index p = src*N + dst, ascending from 0 to N*N-1.
REQ-022 SHALL treat a pair as live when latched bit src is 1, dst != src, and the weight entry is nonzero at the moment of examination.
REQ-023 SHALL, on a live pair, register ev_src/ev_dst/ev_weight and enter EMIT, so ev_valid rises the cycle after examination; a non-live pair costs exactly one SCAN cycle.
REQ-024 SHALL, in EMIT, hold ev_valid=1 and ev_src/ev_dst/ev_weight stable until the cycle where ev_ready=1; ev_valid SHALL be 0 outside EMIT.
REQ-025 SHALL, on the EMIT handshake, advance p and return to SCAN, or enter DONE if p was N*N-1.
REQ-026 SHALL, when SCAN examines p=N*N-1 and it is not live, enter DONE next cycle.
REQ-027 SHALL assert done=1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-028 SHALL NOT let a weight write alter an event already registered in EMIT; writes to pairs not yet examined take effect for the current vector.
REQ-029 SHALL ignore spike_valid/spike_in outside IDLE (no queuing).
REQ-030 SHALL, with no events, take N*N+1 cycles from acceptance to done (N*N SCAN + 1 DONE).

Reset
REQ-031 SHALL, on reset=1 at a posedge, enter IDLE, clear all weight entries, latched spikes and pair counter, regardless of state, including mid-EMIT.
REQ-032 SHALL drive after reset: spike_ready=1, ev_valid=0, ev_src=0, ev_dst=0, ev_weight=0, done=0.
REQ-033 SHALL give reset priority over wr_en and spike_valid in the same cycle.

Verification
REQ-034 SHALL verify: after reset, weights (0,1)=5,(0,3)=9,(2,0)=7; spike_in=4'b0101, ev_ready=1 -> events (0,1,5),(0,3,9),(2,0,7) in that order, then one done pulse.
REQ-035 SHALL verify: same setup, ev_ready held 0 for 3 cycles on first event -> ev_valid high, outputs (0,1,5) stable all 4 cycles, no event lost or duplicated.
REQ-036 SHALL verify: spike_in=4'b0000 accepted -> no ev_valid, done exactly 17 cycles after acceptance (N=4).
REQ-037 SHALL verify: weight (1,1)=3 and (1,2)=0, spike_in=4'b0010 -> no events (self-loop and zero weight skipped), done pulse.
REQ-038 SHALL verify: reset asserted while ev_valid=1 -> next cycle ev_valid=0, spike_ready=1, and a new vector 4'b0001 produces no events (weights cleared).
REQ-039 SHALL verify: during SCAN of src 0, write (3,2)=4 with spike_in=4'b1000 latched -> event (3,2,4) emitted in the current pass.
